// File: rtl/ft_tx_arbiter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ft_tx_arbiter_if : requester-side and bridge-side signals of ft_tx_arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
interface ft_tx_arbiter_if #(
  parameter int NUM_CH    = 4,
  parameter int BUS_WIDTH = 16,
  parameter int LEN_W     = 8
);
  logic [NUM_CH-1:0]           req_valid;
  logic [NUM_CH*LEN_W-1:0]     req_len;
  logic [NUM_CH*BUS_WIDTH-1:0] req_data;
  logic [NUM_CH-1:0]           req_ready;
  logic [NUM_CH-1:0]           req_done;
  logic [BUS_WIDTH-1:0]        ui_din;
  logic [BUS_WIDTH/8-1:0]      ui_din_be;
  logic                        ui_din_valid;
  logic                        ui_din_full;

  modport master (
    input  req_valid, req_len, req_data, ui_din_full,
    output req_ready, req_done, ui_din, ui_din_be, ui_din_valid
  );

  modport slave (
    output req_valid, req_len, req_data, ui_din_full,
    input  req_ready, req_done, ui_din, ui_din_be, ui_din_valid
  );
endinterface
`default_nettype wire

// File: rtl/ft_tx_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ft_tx_arbiter : round-robin packet arbiter, header {SYNC,ch,len} + payload
// Rev 1.0
// ---------------------------------------------------------------------------
module ft_tx_arbiter #(
  parameter int         NUM_CH    = 4,
  parameter int         BUS_WIDTH = 16,
  parameter int         LEN_W     = 8,
  parameter logic [3:0] SYNC      = 4'hA
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           enable,
  ft_tx_arbiter_if.master bus,
  output logic           busy,
  output logic [3:0]     grant_ch
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HDR  = 2'd1;
  localparam logic [1:0] S_PAY  = 2'd2;

  logic [1:0]           state;
  logic [CH_W-1:0]      rr_ptr;
  logic [CH_W-1:0]      gnt;
  logic [CH_W-1:0]      pick;
  logic                 pick_ok;
  logic [LEN_W-1:0]     words_left;
  logic [BUS_WIDTH-1:0] hdr;
  logic                 pay_xfer;

  logic [LEN_W-1:0]     len_arr  [NUM_CH];
  logic [BUS_WIDTH-1:0] data_arr [NUM_CH];

  generate
    for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
      assign len_arr[g]  = bus.req_len[g*LEN_W +: LEN_W];
      assign data_arr[g] = bus.req_data[g*BUS_WIDTH +: BUS_WIDTH];
    end
  endgenerate

  function automatic logic [CH_W-1:0] ch_add(input logic [CH_W-1:0] base, input int off);
    int s;
    s = (int'(base) + off) % NUM_CH;
    return CH_W'(s);
  endfunction

  // Scan from the farthest offset down so the nearest requester after rr_ptr wins.
  always_comb begin
    pick    = '0;
    pick_ok = 1'b0;
    for (int off = NUM_CH; off >= 1; off--) begin
      if (bus.req_valid[ch_add(rr_ptr, off)]) begin
        pick    = ch_add(rr_ptr, off);
        pick_ok = 1'b1;
      end
    end
  end

  assign pay_xfer = (state == S_PAY) && bus.req_valid[gnt] && !bus.ui_din_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      rr_ptr     <= CH_W'(NUM_CH - 1);
      words_left <= '0;
      gnt        <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (enable && pick_ok) begin
            gnt        <= pick;
            words_left <= len_arr[pick];
            state      <= S_HDR;
          end
        end
        S_HDR: begin
          if (!bus.ui_din_full) begin
            rr_ptr <= gnt;
            state  <= (words_left == '0) ? S_IDLE : S_PAY;
          end
        end
        S_PAY: begin
          if (pay_xfer) begin
            words_left <= words_left - LEN_W'(1);
            if (words_left == LEN_W'(1)) state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // words_left still holds the latched length while in HDR.
  always_comb begin
    hdr                          = '0;
    hdr[BUS_WIDTH-1 -: 4]        = SYNC;
    hdr[BUS_WIDTH-5 -: 4]        = 4'(gnt);
    hdr[LEN_W-1:0]               = words_left;
  end

  always_comb begin
    bus.ui_din       = '0;
    bus.ui_din_valid = 1'b0;
    bus.req_ready    = '0;
    bus.req_done     = '0;
    case (state)
      S_HDR: begin
        bus.ui_din       = hdr;
        bus.ui_din_valid = !bus.ui_din_full;
        bus.req_done[gnt] = !bus.ui_din_full && (words_left == '0);
      end
      S_PAY: begin
        bus.ui_din         = data_arr[gnt];
        bus.ui_din_valid   = pay_xfer;
        bus.req_ready[gnt] = pay_xfer;
        bus.req_done[gnt]  = pay_xfer && (words_left == LEN_W'(1));
      end
      default: ;
    endcase
  end

  // Byte enables are all ones in operation but forced low under reset.
  assign bus.ui_din_be = {(BUS_WIDTH/8){rst_n}};
  assign busy          = (state != S_IDLE);
  assign grant_ch      = busy ? 4'(gnt) : 4'd0;

endmodule
`default_nettype wire
